// File: rtl/uart_rx_if.sv
// Line-side and byte-side signals of the 8N1 receiver.
// The slave modport is the receiver; master is the driver/consumer side.
interface uart_rx_if;
   logic       os_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   modport master (output os_tick, rx, input rx_data, rx_valid, rx_busy, frame_err);
   modport slave  (input os_tick, rx, output rx_data, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampling tick enable and 2-FF input synchroniser.
// Optional 2-of-3 majority sampling at each decision point: UART_RX_MAJORITY_EN.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_rx_if.slave   bus
);
   localparam int CW = $clog2(OVERSAMPLE);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

   logic [1:0]    sync_q;
   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic [CW-1:0] dp;
   logic          at_dp;
   logic          samp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], bus.rx};
   end
   assign rx_s = sync_q[1];

   // START decides at mid-bit of the start bit; DATA/STOP one full bit later.
   assign dp    = (state_q == S_START) ? HALF_M1 : FULL_M1;
   assign at_dp = (cnt_q == dp);

`ifdef UART_RX_MAJORITY_EN
   // Two earlier samples are held; the third is the live rx_s on the decision tick.
   logic [1:0] maj_q, maj_d;
   logic       in_frame;

   assign in_frame = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
   assign samp = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);

   always_comb begin
      maj_d = maj_q;
      if (bus.os_tick && in_frame) begin
         if (at_dp)
            maj_d = '0;
         else if (cnt_q == dp - CW'(2) || cnt_q == dp - CW'(1))
            maj_d = {maj_q[0], rx_s};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) maj_q <= '0;
      else        maj_q <= maj_d;
   end
`else
   assign samp = rx_s;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (bus.os_tick) begin
         case (state_q)
            S_IDLE: if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
            S_START: if (at_dp) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = samp ? S_IDLE : S_DATA;
            end else cnt_d = cnt_q + CW'(1);
            S_DATA: if (at_dp) begin
               shift_d = {samp, shift_q[7:1]};
               cnt_d   = '0;
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else cnt_d = cnt_q + CW'(1);
            S_STOP: if (at_dp) begin
               cnt_d = '0;
               if (samp) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else cnt_d = cnt_q + CW'(1);
            // Held-low line must return high before a new frame can start.
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.rx_busy   = (state_q != S_IDLE);
endmodule
